// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: accepts one register command at a time and returns one response.
// A per-command timeout aborts hung transactions; stray B/R beats are drained while idle.
module axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              axi_aclk,
  input  logic                              axi_reset,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_awaddr,
  output logic [2:0]                        M_AXI_awprot,
  output logic                              M_AXI_awvalid,
  input  logic                              M_AXI_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_wstrb,
  output logic                              M_AXI_wvalid,
  input  logic                              M_AXI_wready,
  input  logic [1:0]                        M_AXI_bresp,
  input  logic                              M_AXI_bvalid,
  output logic                              M_AXI_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_araddr,
  output logic [2:0]                        M_AXI_arprot,
  output logic                              M_AXI_arvalid,
  input  logic                              M_AXI_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_rdata,
  input  logic [1:0]                        M_AXI_rresp,
  input  logic                              M_AXI_rvalid,
  output logic                              M_AXI_rready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  state_t                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            arvalid_q, arvalid_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;
  logic                            timeout_q, timeout_d;
  logic                            cmd_ready_q, bready_q, rready_q, rsp_valid_q;
  logic                            cnt_last_s, aw_done_s, w_done_s;

  assign cnt_last_s = (cnt_q == CNT_LAST);
  // A channel counts as done once its valid has dropped or is handshaking this cycle.
  assign aw_done_s  = !awvalid_q || M_AXI_awready;
  assign w_done_s   = !wvalid_q || M_AXI_wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = {CNT_W{1'b0}};
          if (cmd_write) begin
            state_d   = WR_ADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_ADDR_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last_s) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          state_d   = RSP;
          rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
          resp_d    = 2'b10;
          timeout_d = 1'b1;
        end else begin
          awvalid_d = awvalid_q && !M_AXI_awready;
          wvalid_d  = wvalid_q && !M_AXI_wready;
          state_d   = (aw_done_s && w_done_s) ? WR_RESP : WR_ADDR_DATA;
        end
      end
      WR_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (M_AXI_bvalid) begin
          state_d   = RSP;
          rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
          resp_d    = M_AXI_bresp;
          timeout_d = 1'b0;
        end else if (cnt_last_s) begin
          state_d   = RSP;
          rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
          resp_d    = 2'b10;
          timeout_d = 1'b1;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_ADDR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last_s) begin
          arvalid_d = 1'b0;
          state_d   = RSP;
          rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
          resp_d    = 2'b10;
          timeout_d = 1'b1;
        end else if (M_AXI_arready) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (M_AXI_rvalid) begin
          state_d   = RSP;
          rdata_d   = M_AXI_rdata;
          resp_d    = M_AXI_rresp;
          timeout_d = 1'b0;
        end else if (cnt_last_s) begin
          state_d   = RSP;
          rdata_d   = {C_M_AXI_DATA_WIDTH{1'b0}};
          resp_d    = 2'b10;
          timeout_d = 1'b1;
        end else begin
          state_d = RD_DATA;
        end
      end
      RSP: begin
        state_d = rsp_ready ? IDLE : RSP;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so no input reaches an output combinationally.
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q     <= IDLE;
      addr_q      <= {C_M_AXI_ADDR_WIDTH{1'b0}};
      wdata_q     <= {C_M_AXI_DATA_WIDTH{1'b0}};
      wstrb_q     <= {STRB_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rdata_q     <= {C_M_AXI_DATA_WIDTH{1'b0}};
      resp_q      <= 2'b00;
      timeout_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      bready_q    <= 1'b1;
      rready_q    <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      timeout_q   <= timeout_d;
      cmd_ready_q <= (state_d == IDLE);
      bready_q    <= (state_d == IDLE) || (state_d == WR_RESP) || (state_d == RSP);
      rready_q    <= (state_d == IDLE) || (state_d == RD_DATA) || (state_d == RSP);
      rsp_valid_q <= (state_d == RSP);
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;
  assign M_AXI_awaddr  = addr_q;
  assign M_AXI_awprot  = 3'b000;
  assign M_AXI_awvalid = awvalid_q;
  assign M_AXI_wdata   = wdata_q;
  assign M_AXI_wstrb   = wstrb_q;
  assign M_AXI_wvalid  = wvalid_q;
  assign M_AXI_bready  = bready_q;
  assign M_AXI_araddr  = addr_q;
  assign M_AXI_arprot  = 3'b000;
  assign M_AXI_arvalid = arvalid_q;
  assign M_AXI_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a scripted AXI4-Lite slave responds on the falling edge,
// and the main sequence checks latencies, beat counts, timeout, stall and reset behaviour.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        axi_reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [39:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [39:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_chk = 0;
  int n_err = 0;

  // Slave knobs, written only by the main sequence.
  int       aw_lat = 0, w_lat = 0, inj_req = 0;
  bit       ar_hang = 1'b0, b_hold = 1'b0;
  logic [1:0] b_resp_cfg = 2'b00;

  // Slave/monitor state, written only by the slave process.
  int  cyc = 0, acc_cyc = 0, rsp_rise_cyc = 0, aw_fire_cyc = 0, w_fire_cyc = 0;
  int  aw_cnt = 0, w_cnt = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;
  int  aw_beats = 0, w_beats = 0, ar_beats = 0, r_beats = 0, rsp_hs = 0, inj_ack = 0;
  bit  aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, b_fire = 1'b0, r_fire = 1'b0, rsp_prev = 1'b0;
  logic [39:0] cap_awaddr, cap_araddr;
  logic [2:0]  cap_awprot, cap_arprot;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  axi_lite_master #(
    .C_M_AXI_ADDR_WIDTH(40),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .axi_aclk(clk), .axi_reset(axi_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid), .M_AXI_awready(awready),
    .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb), .M_AXI_wvalid(wvalid), .M_AXI_wready(wready),
    .M_AXI_bresp(bresp), .M_AXI_bvalid(bvalid), .M_AXI_bready(bready),
    .M_AXI_araddr(araddr), .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
    .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid), .M_AXI_rready(rready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [39:0] a);
    case (a[31:0])
      32'h0000_0000: rd_model = 32'hDEAD_BEEF;
      32'h0000_0004: rd_model = 32'h7654_3210;
      default:       rd_model = {8'h5A, a[23:0]};
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scripted slave and monitor: acts on the falling edge; a valid&ready seen here fires at the next rising edge.
  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
    bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        aw_beats = 0; w_beats = 0; ar_beats = 0; aw_hi = 0; w_hi = 0; ar_hi = 0; rsp_hs = 0;
      end
      if (axi_reset) begin
        aw_got = 1'b0; w_got = 1'b0; ar_got = 1'b0; b_fire = 1'b0; r_fire = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        aw_cnt = 0; w_cnt = 0;
      end else begin
        if (b_fire) bvalid = 1'b0;
        if (r_fire) rvalid = 1'b0;
        if (awvalid) begin awready = (aw_cnt >= aw_lat); aw_cnt++; aw_hi++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_lat); w_cnt++; w_hi++; end
        else begin wready = 1'b0; w_cnt = 0; end
        if (arvalid) begin arready = !ar_hang; ar_hi++; end
        else arready = 1'b0;
        if (aw_got && w_got && !bvalid && !b_hold) begin
          bvalid = 1'b1; bresp = b_resp_cfg; aw_got = 1'b0; w_got = 1'b0;
        end
        if (ar_got && !rvalid) begin
          rvalid = 1'b1; rdata = rd_model(cap_araddr); rresp = 2'b00; ar_got = 1'b0;
        end else if ((inj_ack != inj_req) && !rvalid) begin
          rvalid = 1'b1; rdata = 32'h0BAD_0BAD; rresp = 2'b00; inj_ack = inj_req;
        end
        if (awvalid && awready) begin
          aw_beats++; aw_got = 1'b1; cap_awaddr = awaddr; cap_awprot = awprot; aw_fire_cyc = cyc;
        end
        if (wvalid && wready) begin
          w_beats++; w_got = 1'b1; cap_wdata = wdata; cap_wstrb = wstrb; w_fire_cyc = cyc;
        end
        if (arvalid && arready) begin
          ar_beats++; ar_got = 1'b1; cap_araddr = araddr; cap_arprot = arprot;
        end
        b_fire = bvalid && bready;
        r_fire = rvalid && rready;
        if (r_fire) r_beats++;
      end
      if (rsp_valid && !rsp_prev) rsp_rise_cyc = cyc;
      rsp_prev = rsp_valid;
      if (rsp_valid && rsp_ready) rsp_hs++;
    end
  end

  task automatic issue(input logic wr, input logic [39:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("cmd_accept", ok, 1);
  endtask

  task automatic collect(output logic [31:0] rd, output logic [1:0] rs, output logic to);
    bit ok;
    ok = 1'b0; rd = 32'h0; rs = 2'b00; to = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout; ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    check_val("rsp_seen", ok, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        to;
    int          r_before;
    bit          seen;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 40'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b1; axi_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 0);
    check_val("rst_awvalid", awvalid, 0);
    check_val("rst_wvalid", wvalid, 0);
    check_val("rst_arvalid", arvalid, 0);
    check_val("rst_bready", bready, 1);
    check_val("rst_rready", rready, 1);
    check_val("rst_rsp_valid", rsp_valid, 0);
    check_val("rst_rsp_fields", {rsp_rdata, rsp_resp, rsp_timeout}, 35'h0);
    @(posedge clk); #1;
    axi_reset = 1'b0;
    @(negedge clk);
    check_val("rel_cmd_ready_0", cmd_ready, 0);
    @(negedge clk);
    check_val("rel_cmd_ready_1", cmd_ready, 1);

    // Zero-wait write
    issue(1'b1, 40'h8, 32'h1234_5678, 4'hF);
    collect(rd, rs, to);
    check_val("wr_awaddr", cap_awaddr, 40'h8);
    check_val("wr_awprot", cap_awprot, 3'b000);
    check_val("wr_wdata", cap_wdata, 32'h1234_5678);
    check_val("wr_wstrb", cap_wstrb, 4'hF);
    check_val("wr_aw_lat", aw_fire_cyc - acc_cyc, 1);
    check_val("wr_w_lat", w_fire_cyc - acc_cyc, 1);
    check_val("wr_rsp_lat", rsp_rise_cyc - acc_cyc, 3);
    check_val("wr_rsp", {rd, rs, to}, {32'h0, 2'b00, 1'b0});

    // Reads from the register model
    issue(1'b0, 40'h0, 32'h0, 4'h0);
    collect(rd, rs, to);
    check_val("rd0_araddr", cap_araddr, 40'h0);
    check_val("rd0_arprot", cap_arprot, 3'b000);
    check_val("rd0_lat", rsp_rise_cyc - acc_cyc, 3);
    check_val("rd0_rsp", {rd, rs, to}, {32'hDEAD_BEEF, 2'b00, 1'b0});
    issue(1'b0, 40'h4, 32'h0, 4'h0);
    collect(rd, rs, to);
    check_val("rd4_rsp", {rd, rs, to}, {32'h7654_3210, 2'b00, 1'b0});

    // AW delayed by 3, W immediate, slave error passed through
    aw_lat = 3; w_lat = 0; b_resp_cfg = 2'b10;
    issue(1'b1, 40'hC, 32'hA5A5_0001, 4'h1);
    collect(rd, rs, to);
    check_val("awdly_aw_hi", aw_hi, 4);
    check_val("awdly_w_hi", w_hi, 1);
    check_val("awdly_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
    check_val("awdly_lat", rsp_rise_cyc - acc_cyc, 6);
    check_val("awdly_rsp", {rd, rs, to}, {32'h0, 2'b10, 1'b0});

    // W delayed by 3, AW immediate
    aw_lat = 0; w_lat = 3; b_resp_cfg = 2'b11;
    issue(1'b1, 40'h10, 32'h0000_5A5A, 4'h3);
    collect(rd, rs, to);
    check_val("wdly_aw_hi", aw_hi, 1);
    check_val("wdly_w_hi", w_hi, 4);
    check_val("wdly_beats", {aw_beats[7:0], w_beats[7:0]}, 16'h0101);
    check_val("wdly_wdata", cap_wdata, 32'h0000_5A5A);
    check_val("wdly_rsp", {rd, rs, to}, {32'h0, 2'b11, 1'b0});
    w_lat = 0; b_resp_cfg = 2'b00;

    // Response stalled for 10 cycles
    rsp_ready = 1'b0;
    issue(1'b0, 40'h0, 32'h0, 4'h0);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    check_val("stall_rsp_rise", seen, 1);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_val("stall_rsp_valid", rsp_valid, 1);
      check_val("stall_rsp_data", {rsp_rdata, rsp_resp, rsp_timeout}, {32'hDEAD_BEEF, 2'b00, 1'b0});
      check_val("stall_cmd_ready", cmd_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    collect(rd, rs, to);
    check_val("stall_rsp", {rd, rs, to}, {32'hDEAD_BEEF, 2'b00, 1'b0});
    @(negedge clk);
    check_val("stall_cmd_ready_after", cmd_ready, 1);
    check_val("stall_rsp_valid_after", rsp_valid, 0);
    @(posedge clk); #1;
    check_val("stall_single_rsp", rsp_hs, 1);

    // Slave never accepts AR: timeout after 16 cycles
    ar_hang = 1'b1;
    issue(1'b0, 40'h20, 32'h0, 4'h0);
    collect(rd, rs, to);
    check_val("to_rsp_lat", rsp_rise_cyc - acc_cyc, 17);
    check_val("to_ar_hi", ar_hi, 16);
    check_val("to_rsp", {rd, rs, to}, {32'h0, 2'b10, 1'b1});
    check_val("to_arvalid", arvalid, 0);
    ar_hang = 1'b0;
    r_before = r_beats;
    inj_req++;
    repeat (4) @(posedge clk);
    #1;
    check_val("to_late_r_drained", r_beats - r_before, 1);
    check_val("to_no_second_rsp", rsp_hs, 1);
    check_val("to_rvalid_gone", rvalid, 0);

    // Reset while waiting for B
    b_hold = 1'b1;
    issue(1'b1, 40'h24, 32'hCAFE_F00D, 4'h3);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if ((aw_beats == 1) && (w_beats == 1)) begin seen = 1'b1; break; end
    end
    check_val("rst_mid_aw_w_done", seen, 1);
    check_val("rst_mid_pre_valids", {awvalid, wvalid, rsp_valid}, 3'b000);
    axi_reset = 1'b1;
    @(posedge clk); #1;
    axi_reset = 1'b0;
    @(negedge clk);
    check_val("rst_mid_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
    check_val("rst_mid_cmd_ready", cmd_ready, 0);
    check_val("rst_mid_ready_drain", {bready, rready}, 2'b11);
    @(negedge clk);
    check_val("rst_mid_cmd_ready_1", cmd_ready, 1);
    check_val("rst_mid_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    check_val("rst_mid_no_hs", rsp_hs, 0);
    b_hold = 1'b0;
    issue(1'b0, 40'h4, 32'h0, 4'h0);
    collect(rd, rs, to);
    check_val("rst_mid_rd_lat", rsp_rise_cyc - acc_cyc, 3);
    check_val("rst_mid_rd_rsp", {rd, rs, to}, {32'h7654_3210, 2'b00, 1'b0});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
